udma_eth_rx_packer: RTL

UDMA_ETH_RX_PACKER -- requirements
Module: udma_eth_rx_packer

---
 rtl/udma_eth_pkg.sv | 16 +
 rtl/eth_rx_word_fifo.sv | 59 +++++
 rtl/udma_eth_rx_packer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/udma_eth_pkg.sv
// Shared definitions for the Ethernet RX to uDMA packer: FSM states,
// status bit positions and the default word FIFO depth.
package udma_eth_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECV     = 2'd1,
    DROP     = 2'd2,
    WAIT_EOF = 2'd3
  } rx_state_e;

  localparam int STAT_BAD       = 0;
  localparam int STAT_OVF       = 1;
  localparam int ETH_FIFO_DEPTH = 8;

endpackage

// File: rtl/eth_rx_word_fifo.sv
// 32-bit show-ahead word FIFO: rdata is the head word whenever valid is high
// and reads zero when empty. A push into a full FIFO succeeds only alongside a pop.
module eth_rx_word_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [31:0]      wdata,
  input  logic             pop,
  output logic [31:0]      rdata,
  output logic             valid,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && valid;
  assign do_push = push && (!full || do_pop);
  assign rdata   = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (do_push && !do_pop) begin
        count <= count + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/udma_eth_rx_packer.sv
// Packs the MAC receive byte stream little-endian into 32-bit words for the
// uDMA RX channel and reports per-frame length and status.
module udma_eth_rx_packer
  import udma_eth_pkg::*;
#(
  parameter int FIFO_DEPTH = ETH_FIFO_DEPTH,
  parameter int LEN_W      = 16
) (
  input  logic                          clk_i,
  input  logic                          rstn_i,
  input  logic                          cfg_en_i,
  input  logic [7:0]                    rx_axis_tdata_i,
  input  logic                          rx_axis_tvalid_i,
  input  logic                          rx_axis_tlast_i,
  input  logic                          rx_axis_tuser_i,
  output logic [31:0]                   data_o,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic                          frame_done_o,
  output logic [LEN_W-1:0]              frame_len_o,
  output logic [1:0]                    frame_status_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic [31:0]      word_q;
  logic [31:0]      push_word_q;
  logic [1:0]       idx_q;
  logic             push_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_final_q;
  logic [LEN_W-1:0] len_next;
  logic             bad_q;
  logic             ovf_q;
  logic             done_pend_q;

  logic             fifo_full;
  logic             pop;
  logic             push;
  logic             push_fail;
  logic             frame_start;
  logic             accept;
  logic             end_frame;
  logic             count_byte;
  logic [1:0]       cur_idx;
  logic [31:0]      cur_word;
  logic [31:0]      packed_word;
  logic             word_done;

  assign pop       = valid_o && ready_i;
  assign push      = push_q && (!fifo_full || pop);
  assign push_fail = push_q && fifo_full && !pop;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // cfg_en_i is only consulted in IDLE, so enable changes take effect at the next frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (rx_axis_tvalid_i) begin
          if (cfg_en_i) begin
            state_d = rx_axis_tlast_i ? IDLE : RECV;
          end else if (!rx_axis_tlast_i) begin
            state_d = WAIT_EOF;
          end
        end
      end
      RECV: begin
        if (push_fail) begin
          state_d = (rx_axis_tvalid_i && rx_axis_tlast_i) ? IDLE : DROP;
        end else if (rx_axis_tvalid_i && rx_axis_tlast_i) begin
          state_d = IDLE;
        end
      end
      DROP, WAIT_EOF: begin
        if (rx_axis_tvalid_i && rx_axis_tlast_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    accept      = 1'b0;
    end_frame   = 1'b0;
    count_byte  = 1'b0;
    case (state_q)
      IDLE: begin
        frame_start = rx_axis_tvalid_i && cfg_en_i;
        accept      = frame_start;
        end_frame   = frame_start && rx_axis_tlast_i;
        count_byte  = frame_start;
      end
      RECV: begin
        accept     = rx_axis_tvalid_i && !push_fail;
        end_frame  = rx_axis_tvalid_i && rx_axis_tlast_i;
        count_byte = rx_axis_tvalid_i;
      end
      DROP: begin
        end_frame  = rx_axis_tvalid_i && rx_axis_tlast_i;
        count_byte = rx_axis_tvalid_i;
      end
      default: begin
        end_frame = 1'b0;
      end
    endcase
  end

  // A new frame ignores whatever a dropped frame left in the packing register.
  assign cur_idx     = frame_start ? 2'd0 : idx_q;
  assign cur_word    = frame_start ? 32'd0 : word_q;
  assign packed_word = cur_word | ({24'd0, rx_axis_tdata_i} << {cur_idx, 3'b000});
  assign word_done   = accept && ((cur_idx == 2'd3) || rx_axis_tlast_i);
  assign len_next    = frame_start ? LEN_W'(1) :
                       ((&len_q) ? len_q : len_q + LEN_W'(1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      word_q      <= '0;
      push_word_q <= '0;
      idx_q       <= '0;
      push_q      <= 1'b0;
      len_q       <= '0;
      len_final_q <= '0;
      bad_q       <= 1'b0;
      ovf_q       <= 1'b0;
      done_pend_q <= 1'b0;
    end else begin
      push_q      <= word_done;
      done_pend_q <= end_frame;
      if (word_done) begin
        push_word_q <= packed_word;
        word_q      <= '0;
        idx_q       <= '0;
      end else if (accept) begin
        word_q <= packed_word;
        idx_q  <= cur_idx + 2'd1;
      end
      if (count_byte) begin
        len_q <= len_next;
      end
      if (frame_start) begin
        ovf_q <= 1'b0;
      end else if (push_fail) begin
        ovf_q <= 1'b1;
      end
      if (end_frame) begin
        len_final_q <= len_next;
        bad_q       <= rx_axis_tuser_i;
      end
    end
  end

  // Frame report lands with the final word's push, so a failed last push still flags overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      frame_done_o   <= 1'b0;
      frame_len_o    <= '0;
      frame_status_o <= '0;
    end else begin
      frame_done_o <= done_pend_q;
      if (done_pend_q) begin
        frame_len_o              <= len_final_q;
        frame_status_o[STAT_OVF] <= ovf_q | push_fail;
        frame_status_o[STAT_BAD] <= bad_q;
      end
    end
  end

  eth_rx_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .CNT_W ($clog2(FIFO_DEPTH) + 1)
  ) u_word_fifo (
    .clk   (clk_i),
    .rst_n (rstn_i),
    .push  (push),
    .wdata (push_word_q),
    .pop   (pop),
    .rdata (data_o),
    .valid (valid_o),
    .full  (fifo_full),
    .count (fifo_count_o)
  );

endmodule
